// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin pick of one ready reservation station per
// cycle, combinational one-hot grant, registered broadcast of the winner's tag/data.
module cdb_arbiter #(
  parameter int num_src    = 4,
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [num_src-1:0]               req_valid,
  input  logic [num_src*tag_width-1:0]     req_tag,
  input  logic [num_src*data_width-1:0]    req_data,
  output logic [num_src-1:0]               grant,
  output logic                             cdb_valid,
  output logic [tag_width-1:0]             cdb_tag,
  output logic [data_width-1:0]            cdb_data
);

  localparam int PTR_W = (num_src > 1) ? $clog2(num_src) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [tag_width-1:0]  cdb_tag_q, cdb_tag_d;
  logic [data_width-1:0] cdb_data_q, cdb_data_d;

  logic                  win_vld;
  logic [PTR_W-1:0]      win_idx;
  logic [tag_width-1:0]  sel_tag;
  logic [data_width-1:0] sel_data;

  // Search from ptr upward with wrap; first requester found wins.
  always_comb begin
    int unsigned j;
    logic [PTR_W-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    for (int k = 0; k < num_src; k++) begin
      j = int'(ptr_q) + k;
      if (j >= num_src) j = j - num_src;
      idx = PTR_W'(j);
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
    // Flush and reset suppress any grant in the same cycle.
    if (flush || !rst_n) win_vld = 1'b0;
  end

  always_comb begin
    grant    = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < num_src; i++) begin
      if (win_vld && win_idx == PTR_W'(i)) begin
        grant[i] = 1'b1;
        sel_tag  = req_tag[i*tag_width +: tag_width];
        sel_data = req_data[i*data_width +: data_width];
      end
    end
  end

  always_comb begin
    cdb_valid_d = win_vld;
    cdb_tag_d   = win_vld ? sel_tag  : cdb_tag_q;
    cdb_data_d  = win_vld ? sel_data : cdb_data_q;
    ptr_d       = ptr_q;
    if (flush)
      ptr_d = '0;
    else if (win_vld)
      ptr_d = (win_idx == PTR_W'(num_src - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table on a 4-source instance plus hand
// sequences for asynchronous reset and a 3-source (non power of two) instance.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [11:0] req_tag;
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;

  logic        flush3;
  logic [2:0]  req_valid3;
  logic [8:0]  req_tag3;
  logic [47:0] req_data3;
  logic [2:0]  grant3;
  logic        cdb_valid3;
  logic [2:0]  cdb_tag3;
  logic [15:0] cdb_data3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.num_src(4), .data_width(16), .tag_width(3)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid),
    .req_tag(req_tag), .req_data(req_data), .grant(grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data));

  cdb_arbiter #(.num_src(3), .data_width(16), .tag_width(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .req_valid(req_valid3),
    .req_tag(req_tag3), .req_data(req_data3), .grant(grant3),
    .cdb_valid(cdb_valid3), .cdb_tag(cdb_tag3), .cdb_data(cdb_data3));

  typedef struct {
    logic        fl;
    logic [3:0]  rv;
    logic [11:0] tg;
    logic [63:0] dt;
    logic [3:0]  eg;
    logic        ev;
    logic [2:0]  et;
    logic [15:0] ed;
    logic [1:0]  ep;
  } vec_t;

  localparam logic [11:0] DTG = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [63:0] DDT = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
  localparam logic [11:0] BTG = {3'd3, 3'd2, 3'd5, 3'd0};
  localparam logic [63:0] BDT = {16'hA003, 16'hA002, 16'hBEEF, 16'hA000};

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int n);
    @(negedge clk);
    flush = v.fl; req_valid = v.rv; req_tag = v.tg; req_data = v.dt;
    #1;
    chk($sformatf("v%0d grant", n), 64'(grant), 64'(v.eg));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cdb_valid", n), 64'(cdb_valid), 64'(v.ev));
    chk($sformatf("v%0d cdb_tag", n), 64'(cdb_tag), 64'(v.et));
    chk($sformatf("v%0d cdb_data", n), 64'(cdb_data), 64'(v.ed));
    chk($sformatf("v%0d ptr", n), 64'(u4.ptr_q), 64'(v.ep));
  endtask

  initial begin
    logic [2:0] exp_g3[4];
    logic [1:0] exp_p3[4];
    vec_t v;
    exp_g3 = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_p3 = '{2'd1, 2'd2, 2'd0, 2'd1};

    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_tag = DTG; req_data = DDT;
    flush3 = 1'b0; req_valid3 = '0;
    req_tag3 = {3'd6, 3'd5, 3'd4}; req_data3 = {16'hC002, 16'hC001, 16'hC000};

    //         fl    rv       tg   dt   eg       ev    et    ed        ep
    tbl.push_back('{1'b0, 4'b0100, DTG, DDT, 4'b0100, 1'b1, 3'd2, 16'hA002, 2'd3});
    tbl.push_back('{1'b0, 4'b0000, DTG, DDT, 4'b0000, 1'b0, 3'd2, 16'hA002, 2'd3});
    tbl.push_back('{1'b0, 4'b1001, DTG, DDT, 4'b1000, 1'b1, 3'd3, 16'hA003, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, DTG, DDT, 4'b0001, 1'b1, 3'd0, 16'hA000, 2'd1});
    tbl.push_back('{1'b0, 4'b0010, BTG, BDT, 4'b0010, 1'b1, 3'd5, 16'hBEEF, 2'd2});
    tbl.push_back('{1'b0, 4'b0000, DTG, DDT, 4'b0000, 1'b0, 3'd5, 16'hBEEF, 2'd2});
    tbl.push_back('{1'b1, 4'b0101, DTG, DDT, 4'b0000, 1'b0, 3'd5, 16'hBEEF, 2'd0});
    tbl.push_back('{1'b0, 4'b0101, DTG, DDT, 4'b0001, 1'b1, 3'd0, 16'hA000, 2'd1});
    tbl.push_back('{1'b1, 4'b1111, DTG, DDT, 4'b0000, 1'b0, 3'd0, 16'hA000, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, DTG, DDT, 4'b0001, 1'b1, 3'd0, 16'hA000, 2'd1});
    tbl.push_back('{1'b0, 4'b1110, DTG, DDT, 4'b0010, 1'b1, 3'd1, 16'hA001, 2'd2});
    tbl.push_back('{1'b0, 4'b1100, DTG, DDT, 4'b0100, 1'b1, 3'd2, 16'hA002, 2'd3});
    tbl.push_back('{1'b0, 4'b1000, DTG, DDT, 4'b1000, 1'b1, 3'd3, 16'hA003, 2'd0});
    tbl.push_back('{1'b0, 4'b0000, DTG, DDT, 4'b0000, 1'b0, 3'd3, 16'hA003, 2'd0});

    // Reset state, with a request pending while held in reset.
    repeat (2) @(posedge clk);
    req_valid = 4'b0100;
    #1;
    chk("rst grant", 64'(grant), 64'h0);
    chk("rst cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst cdb_tag", 64'(cdb_tag), 64'h0);
    chk("rst cdb_data", 64'(cdb_data), 64'h0);
    chk("rst ptr", 64'(u4.ptr_q), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;

    foreach (tbl[i]) step(tbl[i], i);

    // Asynchronous reset mid-cycle while the CDB holds a valid broadcast.
    v = '{1'b0, 4'b0010, DTG, DDT, 4'b0010, 1'b1, 3'd1, 16'hA001, 2'd2};
    step(v, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async cdb_valid", 64'(cdb_valid), 64'h0);
    chk("async cdb_tag", 64'(cdb_tag), 64'h0);
    chk("async cdb_data", 64'(cdb_data), 64'h0);
    chk("async grant", 64'(grant), 64'h0);
    chk("async ptr", 64'(u4.ptr_q), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b0, 4'b0100, DTG, DDT, 4'b0100, 1'b1, 3'd2, 16'hA002, 2'd3};
    step(v, 101);
    @(negedge clk);
    req_valid = '0;

    // Three sources, all requesting continuously: pointer must wrap 2 -> 0.
    @(negedge clk);
    req_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("n3 c%0d grant", c), 64'(grant3), 64'(exp_g3[c]));
      @(posedge clk);
      #1;
      chk($sformatf("n3 c%0d cdb_tag", c), 64'(cdb_tag3), 64'(3'd4 + 3'(c % 3)));
      chk($sformatf("n3 c%0d ptr", c), 64'(u3.ptr_q), 64'(exp_p3[c]));
      @(negedge clk);
    end
    req_valid3 = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
